sprite_tex_loader: RTL and testbench

- Write-side master for the sprite renderer's three texture-load ports: bird, pipe and base.
- On a start pulse it fetches three contiguous RGB565 images from the SDRAM read port in bounded bursts.
- Each returned word becomes a one-cycle write strobe with a sequential address on the matching port.
- Runs in the 50 MHz load-clock domain and asserts done when all three images have been delivered.

---
 rtl/sprite_tex_loader_if.sv | 35 +++
 rtl/sprite_tex_loader.sv | 209 ++++++++++++++++++++
 tb/tb_sprite_tex_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_tex_loader_if.sv
// Bus bundle between the sprite texture loader, the SDRAM read port and the
// three sprite texture RAM write ports.
interface sprite_tex_loader_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [23:0] cmd_addr;
   logic [8:0]  cmd_len;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        bird_load_en;
   logic [12:0] bird_load_addr;
   logic        pipe_load_en;
   logic [15:0] pipe_load_addr;
   logic        base_load_en;
   logic [13:0] base_load_addr;
   logic [15:0] load_data;

   modport master (
      output cmd_valid, cmd_addr, cmd_len,
      input  cmd_ready, rd_valid, rd_data,
      output bird_load_en, bird_load_addr,
      output pipe_load_en, pipe_load_addr,
      output base_load_en, base_load_addr,
      output load_data
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len,
      output cmd_ready, rd_valid, rd_data,
      input  bird_load_en, bird_load_addr,
      input  pipe_load_en, pipe_load_addr,
      input  base_load_en, base_load_addr,
      input  load_data
   );
endinterface

// File: rtl/sprite_tex_loader.sv
// Fetches the bird, pipe and base RGB565 images from SDRAM in bounded bursts
// and replays each returned word as a write strobe on the matching texture RAM.
module sprite_tex_loader #(
   parameter int          BIRD_WORDS = 5250,
   parameter int          PIPE_WORDS = 40000,
   parameter int          BASE_WORDS = 9600,
   parameter logic [23:0] BIRD_SRC   = 24'h000000,
   parameter logic [23:0] PIPE_SRC   = 24'h002000,
   parameter logic [23:0] BASE_SRC   = 24'h00C000,
   parameter int          BURST_LEN  = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   sprite_tex_loader_if.master bus,
   output logic                busy,
   output logic                done,
   output logic [1:0]          dbg_state
);

   // Command handshake: cmd_addr/cmd_len are held while cmd_valid is high and
   // the command is taken on the cycle cmd_valid & cmd_ready. Read data has no
   // back-pressure: every rd_valid cycle in STREAM is one word of the burst.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CMD    = 2'd1,
      S_STREAM = 2'd2,
      S_FINISH = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      A_BIRD = 2'd0,
      A_PIPE = 2'd1,
      A_BASE = 2'd2
   } asset_e;

   localparam logic [15:0] BIRD_N  = 16'(BIRD_WORDS);
   localparam logic [15:0] PIPE_N  = 16'(PIPE_WORDS);
   localparam logic [15:0] BASE_N  = 16'(BASE_WORDS);
   localparam logic [15:0] BURST_N = 16'(BURST_LEN);
   localparam logic [8:0]  BURST_L = 9'(BURST_LEN);

   state_e      state_q, state_d;
   asset_e      asset_q, asset_d;
   logic [15:0] remaining_q, remaining_d;
   logic [8:0]  burst_cnt_q, burst_cnt_d;
   logic [15:0] idx_q, idx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] load_data_q, load_data_d;
   logic        bird_en_q, bird_en_d;
   logic        pipe_en_q, pipe_en_d;
   logic        base_en_q, base_en_d;
   logic [12:0] bird_addr_q, bird_addr_d;
   logic [15:0] pipe_addr_q, pipe_addr_d;
   logic [13:0] base_addr_q, base_addr_d;

   logic [15:0] total_w;
   logic [23:0] src_w;
   logic [15:0] issued_w;
   logic [8:0]  len_w;

   always_comb begin
      total_w = BIRD_N;
      src_w   = BIRD_SRC;
      case (asset_q)
         A_BIRD:  begin total_w = BIRD_N; src_w = BIRD_SRC; end
         A_PIPE:  begin total_w = PIPE_N; src_w = PIPE_SRC; end
         A_BASE:  begin total_w = BASE_N; src_w = BASE_SRC; end
         default: begin total_w = BIRD_N; src_w = BIRD_SRC; end
      endcase
   end

   // Bursts always complete before the next command, so the words still owed
   // for the asset also locate the next burst inside the source image.
   assign issued_w = total_w - remaining_q;
   assign len_w    = (remaining_q > BURST_N) ? BURST_L : remaining_q[8:0];

   always_comb begin
      state_d     = state_q;
      asset_d     = asset_q;
      remaining_d = remaining_q;
      burst_cnt_d = burst_cnt_q;
      idx_d       = idx_q;
      busy_d      = busy_q;
      done_d      = done_q;
      load_data_d = load_data_q;
      bird_en_d   = 1'b0;
      pipe_en_d   = 1'b0;
      base_en_d   = 1'b0;
      bird_addr_d = bird_addr_q;
      pipe_addr_d = pipe_addr_q;
      base_addr_d = base_addr_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d      = 1'b1;
               done_d      = 1'b0;
               asset_d     = A_BIRD;
               remaining_d = BIRD_N;
               idx_d       = '0;
               state_d     = S_CMD;
            end
         end

         S_CMD: begin
            if (bus.cmd_ready) begin
               burst_cnt_d = len_w;
               state_d     = S_STREAM;
            end
         end

         S_STREAM: begin
            if (bus.rd_valid) begin
               load_data_d = bus.rd_data;
               case (asset_q)
                  A_BIRD: begin bird_en_d = 1'b1; bird_addr_d = idx_q[12:0]; end
                  A_PIPE: begin pipe_en_d = 1'b1; pipe_addr_d = idx_q; end
                  A_BASE: begin base_en_d = 1'b1; base_addr_d = idx_q[13:0]; end
                  default: ;
               endcase
               idx_d       = idx_q + 16'd1;
               burst_cnt_d = burst_cnt_q - 9'd1;
               remaining_d = remaining_q - 16'd1;

               if (burst_cnt_q == 9'd1) begin
                  if (remaining_q != 16'd1) begin
                     state_d = S_CMD;
                  end else begin
                     case (asset_q)
                        A_BIRD: begin
                           asset_d     = A_PIPE;
                           remaining_d = PIPE_N;
                           idx_d       = '0;
                           state_d     = S_CMD;
                        end
                        A_PIPE: begin
                           asset_d     = A_BASE;
                           remaining_d = BASE_N;
                           idx_d       = '0;
                           state_d     = S_CMD;
                        end
                        default: state_d = S_FINISH;
                     endcase
                  end
               end
            end
         end

         S_FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         asset_q     <= A_BIRD;
         remaining_q <= '0;
         burst_cnt_q <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         load_data_q <= '0;
         bird_en_q   <= 1'b0;
         pipe_en_q   <= 1'b0;
         base_en_q   <= 1'b0;
         bird_addr_q <= '0;
         pipe_addr_q <= '0;
         base_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         asset_q     <= asset_d;
         remaining_q <= remaining_d;
         burst_cnt_q <= burst_cnt_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         load_data_q <= load_data_d;
         bird_en_q   <= bird_en_d;
         pipe_en_q   <= pipe_en_d;
         base_en_q   <= base_en_d;
         bird_addr_q <= bird_addr_d;
         pipe_addr_q <= pipe_addr_d;
         base_addr_q <= base_addr_d;
      end
   end

   assign bus.cmd_valid      = (state_q == S_CMD);
   assign bus.cmd_addr       = (state_q == S_CMD) ? (src_w + {8'd0, issued_w}) : 24'd0;
   assign bus.cmd_len        = (state_q == S_CMD) ? len_w : 9'd0;
   assign bus.load_data      = load_data_q;
   assign bus.bird_load_en   = bird_en_q;
   assign bus.bird_load_addr = bird_addr_q;
   assign bus.pipe_load_en   = pipe_en_q;
   assign bus.pipe_load_addr = pipe_addr_q;
   assign bus.base_load_en   = base_en_q;
   assign bus.base_load_addr = base_addr_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_sprite_tex_loader.sv
// Scoreboard bench for sprite_tex_loader: a responder models the SDRAM read
// port and queues the expected writes, a negedge monitor checks every strobe.
module tb_sprite_tex_loader;

   localparam int unsigned BIRD_N = 5250;
   localparam int unsigned PIPE_N = 40000;
   localparam int unsigned BASE_N = 9600;
   localparam int unsigned BL     = 256;
   localparam logic [23:0] BIRD_A = 24'h000000;
   localparam logic [23:0] PIPE_A = 24'h002000;
   localparam logic [23:0] BASE_A = 24'h00C000;

   typedef struct packed {
      logic [1:0]  asset;
      logic [15:0] addr;
      logic [15:0] data;
      logic [31:0] due;
   } exp_t;

   logic clk = 1'b0;
   logic rst, start, busy, done;
   logic [1:0] dbg_state;
   logic s_rst, s_start, s_busy, s_done;
   logic [1:0] s_dbg;

   sprite_tex_loader_if bus ();
   sprite_tex_loader_if sbus ();

   sprite_tex_loader u_dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   sprite_tex_loader #(
      .BIRD_WORDS(40), .PIPE_WORDS(100), .BASE_WORDS(256), .BURST_LEN(128)
   ) u_small (
      .clk(clk), .rst(s_rst), .start(s_start), .bus(sbus),
      .busy(s_busy), .done(s_done), .dbg_state(s_dbg)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t        exp_q[$];
   logic [32:0] cmd_q[$];
   int unsigned granted = 0;
   int unsigned sent    = 0;
   logic        rand_gap = 1'b0;
   logic        spur     = 1'b0;

   int unsigned n_bird, n_pipe, n_base, n_bird_cmd;
   logic [15:0] last_bird, last_pipe, last_base;
   logic        pipe_1000 = 1'b0;
   logic        done_pend = 1'b0;
   logic        prev_acc  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic int unsigned words_of(input logic [1:0] a);
      case (a)
         2'd0:    return BIRD_N;
         2'd1:    return PIPE_N;
         default: return BASE_N;
      endcase
   endfunction

   task automatic push_cmds();
      int unsigned total, off, len;
      logic [23:0] src;
      for (int a = 0; a < 3; a++) begin
         total = words_of(2'(a));
         src   = (a == 0) ? BIRD_A : (a == 1) ? PIPE_A : BASE_A;
         off   = 0;
         while (off < total) begin
            len = (total - off > BL) ? BL : total - off;
            cmd_q.push_back({src + 24'(off), 9'(len)});
            off += len;
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, {26'd0, busy, done, bus.cmd_valid, bus.bird_load_en,
                          bus.pipe_load_en, bus.base_load_en}, 32'd0);
      chk({tag, "_cmd_addr"}, 32'(bus.cmd_addr), 32'd0);
      chk({tag, "_cmd_len"}, 32'(bus.cmd_len), 32'd0);
      chk({tag, "_bird_pipe_addr"}, {3'd0, bus.bird_load_addr, bus.pipe_load_addr}, 32'd0);
      chk({tag, "_base_addr_data"}, {2'd0, bus.base_load_addr, bus.load_data}, 32'd0);
   endtask

   // SDRAM read-port model: returns granted words and queues the expected writes.
   initial begin
      logic [1:0]  m_asset;
      logic [15:0] m_idx;
      logic [15:0] d;
      exp_t        re;
      bus.rd_valid = 1'b0;
      bus.rd_data  = '0;
      m_asset = 2'd0;
      m_idx   = '0;
      forever begin
         @(posedge clk); #1;
         bus.rd_valid = 1'b0;
         if (rst) begin
            m_asset = 2'd0;
            m_idx   = '0;
         end else if (granted != sent) begin
            if (!rand_gap || $urandom_range(0, 1) == 1) begin
               d            = 16'($urandom);
               bus.rd_valid = 1'b1;
               bus.rd_data  = d;
               sent++;
               re.asset = m_asset; re.addr = m_idx; re.data = d; re.due = cyc + 1;
               exp_q.push_back(re);
               m_idx++;
               if (32'(m_idx) == words_of(m_asset)) begin
                  m_asset = (m_asset == 2'd2) ? 2'd0 : m_asset + 2'd1;
                  m_idx   = '0;
               end
            end
         end else if (spur) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = 16'hBAD0;
         end
      end
   end

   always @(negedge clk) begin
      int          en_cnt;
      exp_t        me;
      logic [1:0]  act_a;
      logic [15:0] act_addr;
      logic [32:0] c;
      if (rst) begin
         exp_q.delete();
         cmd_q.delete();
         granted   = sent;
         prev_acc  = 1'b0;
         done_pend = 1'b0;
      end else begin
         if (start && !busy) begin
            n_bird = 0; n_pipe = 0; n_base = 0; n_bird_cmd = 0; pipe_1000 = 1'b0;
         end
         if (done_pend) begin
            chk("done_after_finish", 32'(done), 32'd1);
            chk("busy_after_finish", 32'(busy), 32'd0);
            done_pend = 1'b0;
         end
         if (prev_acc) chk("cmd_valid_drop", 32'(bus.cmd_valid), 32'd0);
         prev_acc = bus.cmd_valid && bus.cmd_ready;
         if (prev_acc) begin
            chk("one_burst_outstanding", granted - sent, 32'd0);
            chk("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
            if (cmd_q.size() != 0) begin
               c = cmd_q.pop_front();
               chk("cmd_addr", 32'(bus.cmd_addr), 32'(c[32:9]));
               chk("cmd_len", 32'(bus.cmd_len), 32'(c[8:0]));
            end
            if (bus.cmd_addr < PIPE_A) n_bird_cmd++;
            granted += 32'(bus.cmd_len);
         end
         en_cnt = int'(bus.bird_load_en) + int'(bus.pipe_load_en) + int'(bus.base_load_en);
         if (en_cnt != 0) begin
            chk("one_strobe", en_cnt, 32'd1);
            act_a    = bus.pipe_load_en ? 2'd1 : bus.base_load_en ? 2'd2 : 2'd0;
            act_addr = bus.pipe_load_en ? bus.pipe_load_addr :
                       bus.base_load_en ? {2'd0, bus.base_load_addr} : {3'd0, bus.bird_load_addr};
            chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               me = exp_q.pop_front();
               chk("strobe_asset", 32'(act_a), 32'(me.asset));
               chk("strobe_addr", 32'(act_addr), 32'(me.addr));
               chk("strobe_data", 32'(bus.load_data), 32'(me.data));
               chk("strobe_latency", cyc, me.due);
            end
            if (bus.bird_load_en) begin n_bird++; last_bird = {3'd0, bus.bird_load_addr}; end
            if (bus.pipe_load_en) begin n_pipe++; last_pipe = bus.pipe_load_addr; end
            if (bus.base_load_en) begin n_base++; last_base = {2'd0, bus.base_load_addr}; end
            if (bus.pipe_load_en && bus.pipe_load_addr == 16'd1000) pipe_1000 = 1'b1;
            if (bus.base_load_en && 32'(bus.base_load_addr) == BASE_N - 1) done_pend = 1'b1;
         end
         if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            me = exp_q.pop_front();
            chk("strobe_missing", cyc, me.due);
         end
      end
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: got %0d cycles expected fewer than 95000", cyc);
      $fatal(1, "cycle limit reached");
   end

   initial begin
      int i;
      int s_left, s_cmds, s_base_cmds, s_bad_len, s_zero, s_base_n;
      logic [15:0] s_last;
      rst = 1'b1; start = 1'b0; bus.cmd_ready = 1'b0;
      s_rst = 1'b1; s_start = 1'b0; sbus.cmd_ready = 1'b1;
      sbus.rd_valid = 1'b0; sbus.rd_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      chk("reset_state", 32'(dbg_state), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Full gapless load, with a stray start mid-run that must be ignored.
      @(negedge clk);
      push_cmds();
      bus.cmd_ready = 1'b1;
      pulse_start();
      repeat (2000) @(negedge clk);
      pulse_start();
      for (i = 0; i < 60000 && !done; i++) @(negedge clk);
      chk("run1_done", 32'(done), 32'd1);
      @(negedge clk);
      chk("bird_strobes", n_bird, BIRD_N);
      chk("pipe_strobes", n_pipe, PIPE_N);
      chk("base_strobes", n_base, BASE_N);
      chk("bird_last_addr", 32'(last_bird), BIRD_N - 1);
      chk("pipe_last_addr", 32'(last_pipe), PIPE_N - 1);
      chk("base_last_addr", 32'(last_base), BASE_N - 1);
      chk("bird_cmds", n_bird_cmd, 32'd21);
      chk("cmds_all_seen", 32'(cmd_q.size()), 32'd0);

      // Rerun with command back-pressure, spurious rd_valid and gappy data.
      rand_gap = 1'b1;
      bus.cmd_ready = 1'b0;
      push_cmds();
      @(posedge clk); #1 start = 1'b1; spur = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("restart_done_clear", 32'(done), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 4) spur = 1'b0;
         chk("hold_cmd_valid", 32'(bus.cmd_valid), 32'd1);
         chk("hold_cmd_addr", 32'(bus.cmd_addr), 32'(BIRD_A));
         chk("hold_cmd_len", 32'(bus.cmd_len), BL);
         chk("hold_no_strobe", {29'd0, bus.bird_load_en, bus.pipe_load_en, bus.base_load_en}, 32'd0);
      end
      @(posedge clk); #1 bus.cmd_ready = 1'b1;
      @(negedge clk);
      chk("accept_cmd_valid", 32'(bus.cmd_valid), 32'd1);
      @(negedge clk);
      chk("accept_to_stream", 32'(dbg_state), 32'd2);
      for (i = 0; i < 20000 && !pipe_1000; i++) @(negedge clk);
      chk("reached_pipe_1000", 32'(pipe_1000), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("abort");
      @(posedge clk); #1 rst = 1'b0;
      rand_gap = 1'b0;

      // Restart after the abort: bird stream must begin at address 0 again.
      @(negedge clk);
      push_cmds();
      pulse_start();
      for (i = 0; i < 1000 && n_bird < 300; i++) @(negedge clk);
      chk("restart_bird_words", 32'(n_bird >= 300), 32'd1);
      chk("restart_done_low", 32'(done), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);

      // Small build: base of 256 words with 128-word bursts.
      s_left = 0; s_cmds = 0; s_base_cmds = 0; s_bad_len = 0; s_zero = 0; s_base_n = 0;
      s_last = '0;
      #1 s_rst = 1'b0;
      @(posedge clk); #1 s_start = 1'b1;
      @(posedge clk); #1 s_start = 1'b0;
      for (i = 0; i < 3000 && !s_done; i++) begin
         @(negedge clk);
         if (sbus.cmd_valid && sbus.cmd_ready) begin
            s_cmds++;
            if (sbus.cmd_len == 9'd0) s_zero++;
            if (sbus.cmd_addr >= BASE_A) begin
               s_base_cmds++;
               if (sbus.cmd_len != 9'd128) s_bad_len++;
            end
            s_left += int'(sbus.cmd_len);
         end
         if (sbus.base_load_en) begin s_base_n++; s_last = {2'd0, sbus.base_load_addr}; end
         @(posedge clk); #1;
         sbus.rd_valid = (s_left > 0);
         sbus.rd_data  = 16'(i);
         if (s_left > 0) s_left--;
      end
      chk("small_done", 32'(s_done), 32'd1);
      chk("small_total_cmds", s_cmds, 32'd4);
      chk("small_base_cmds", s_base_cmds, 32'd2);
      chk("small_base_len", s_bad_len, 32'd0);
      chk("small_zero_len", s_zero, 32'd0);
      chk("small_base_strobes", s_base_n, 32'd256);
      chk("small_base_last", 32'(s_last), 32'd255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
